// File: rtl/rl_pkg.sv
// Shared types and default sizes for the unary RL datapath.
package rl_pkg;

  localparam int QW          = 4;
  localparam int NUM_ACTIONS = 4;
  localparam int AW          = $clog2(NUM_ACTIONS);
  localparam int SW          = 4;

  typedef logic [QW-1:0] q_t;
  typedef logic [AW-1:0] action_t;
  typedef logic [SW-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    WRITE  = 2'd3
  } sel_state_t;

endpackage

// File: rtl/unary_stream_gen.sv
// Combinational unary stream generator: one comparator per action against
// the shared time counter, plus the OR of all streams.
module unary_stream_gen #(
  parameter int QW          = 4,
  parameter int NUM_ACTIONS = 4
) (
  input  logic [NUM_ACTIONS*QW-1:0] q_flat,
  input  logic [QW-1:0]             t,
  output logic [NUM_ACTIONS-1:0]    s,
  output logic                      or_s
);

  for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_cmp
    assign s[gi] = (q_flat[gi*QW +: QW] > t);
  end

  assign or_s = |s;

endmodule

// File: rtl/unary_argmax_sel.sv
// Greedy-action selector between the Q-table and the policy table.
// Reads all Q-values of one state, finds max/argmax by unary streaming and
// writes the winning action to the policy table.
// Build option: define UNARY_EARLY_TERM_EN to leave STREAM as soon as every
// stream has dropped; otherwise STREAM always spans the full unary period.
module unary_argmax_sel
  import rl_pkg::*;
#(
  parameter int QW          = rl_pkg::QW,
  parameter int NUM_ACTIONS = rl_pkg::NUM_ACTIONS,
  parameter int AW          = $clog2(NUM_ACTIONS),
  parameter int SW          = rl_pkg::SW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [SW-1:0]    i_state,
  output logic             o_busy,
  output logic             o_done,
  output logic [QW-1:0]    o_max_q,
  output logic [AW-1:0]    o_action,
  output logic [SW+AW-1:0] o_q_addr_r,
  output logic             o_q_read_en,
  input  logic [QW-1:0]    i_q_data,
  output logic [SW-1:0]    o_p_addr_w,
  output logic             o_p_write_en,
  output logic [AW-1:0]    o_p_data
);

  localparam logic [AW:0] K_LAST = (AW+1)'(NUM_ACTIONS);

  sel_state_t             state_reg, state_next;
  logic [SW-1:0]          sidx_reg;
  logic [AW:0]            k_reg;
  logic [QW-1:0]          t_reg;
  logic [QW-1:0]          q_reg [NUM_ACTIONS];
  logic [NUM_ACTIONS*QW-1:0] q_flat;
  logic [NUM_ACTIONS-1:0] mask_reg;
  logic [QW-1:0]          max_q_reg;
  logic [AW-1:0]          action_reg;
  logic [NUM_ACTIONS-1:0] s;
  logic                   or_s;
  logic [AW-1:0]          lsb_idx;
  logic                   stream_last;
  logic [QW-1:0]          exit_max;

`ifdef UNARY_EARLY_TERM_EN
  assign stream_last = ~or_s;
  assign exit_max    = t_reg;
`else
  // Once the OR first drops, the result is latched here and the stream
  // keeps running idle until the end of the period.
  logic          found_reg;
  logic [QW-1:0] fmax_reg;
  assign stream_last = (t_reg == {QW{1'b1}});
  assign exit_max    = found_reg ? fmax_reg : t_reg;
`endif

  // Per-action Q registers, filled one cycle after each read is issued.
  for (genvar gi = 0; gi < NUM_ACTIONS; gi++) begin : g_q
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        q_reg[gi] <= '0;
      end else if (state_reg == FETCH && k_reg == (AW+1)'(gi + 1)) begin
        q_reg[gi] <= i_q_data;
      end
    end
    assign q_flat[gi*QW +: QW] = q_reg[gi];
  end

  unary_stream_gen #(
    .QW          (QW),
    .NUM_ACTIONS (NUM_ACTIONS)
  ) u_stream (
    .q_flat (q_flat),
    .t      (t_reg),
    .s      (s),
    .or_s   (or_s)
  );

  // Lowest set bit of the candidate mask; scanning downwards lets low indices win ties.
  always_comb begin
    lsb_idx = '0;
    for (int i = NUM_ACTIONS - 1; i >= 0; i--) begin
      if (mask_reg[i]) lsb_idx = AW'(i);
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and table-interface outputs.
  always_comb begin
    state_next   = state_reg;
    o_q_read_en  = 1'b0;
    o_q_addr_r   = '0;
    o_p_write_en = 1'b0;
    o_p_addr_w   = '0;
    o_p_data     = '0;
    o_done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) state_next = FETCH;
      end
      FETCH: begin
        if (k_reg < K_LAST) begin
          o_q_read_en = 1'b1;
          o_q_addr_r  = {sidx_reg, k_reg[AW-1:0]};
        end else begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (stream_last) state_next = WRITE;
      end
      WRITE: begin
        o_p_write_en = 1'b1;
        o_p_addr_w   = sidx_reg;
        o_p_data     = action_reg;
        o_done       = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: state capture, fetch counter, time counter, mask and results.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sidx_reg   <= '0;
      k_reg      <= '0;
      t_reg      <= '0;
      mask_reg   <= '0;
      max_q_reg  <= '0;
      action_reg <= '0;
`ifndef UNARY_EARLY_TERM_EN
      found_reg  <= 1'b0;
      fmax_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            sidx_reg <= i_state;
            k_reg    <= '0;
          end
        end
        FETCH: begin
          k_reg <= k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            t_reg    <= '0;
            mask_reg <= '1;
`ifndef UNARY_EARLY_TERM_EN
            found_reg <= 1'b0;
`endif
          end
        end
        STREAM: begin
`ifdef UNARY_EARLY_TERM_EN
          if (or_s) begin
            mask_reg <= s;
            t_reg    <= t_reg + 1'b1;
          end else begin
            max_q_reg  <= exit_max;
            action_reg <= lsb_idx;
          end
`else
          if (!found_reg) begin
            if (or_s) begin
              mask_reg <= s;
            end else begin
              found_reg <= 1'b1;
              fmax_reg  <= t_reg;
            end
          end
          if (stream_last) begin
            max_q_reg  <= exit_max;
            action_reg <= lsb_idx;
          end else begin
            t_reg <= t_reg + 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (state_reg != IDLE);
  assign o_max_q  = max_q_reg;
  assign o_action = action_reg;

endmodule
